// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shift-op codes and iterative shifter FSM state encoding
package riscv_pkg;

   localparam logic [1:0] SHOP_SLL = 2'b00;
   localparam logic [1:0] SHOP_SRL = 2'b01;
   localparam logic [1:0] SHOP_SRA = 2'b10;
   localparam logic [1:0] SHOP_ROL = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/nbit_shift_step.sv
// rtl/nbit_shift_step.sv - one combinational shift step of 0..STEP positions
module nbit_shift_step #(
   parameter int N    = 32,
   parameter int STEP = 1,
   parameter int KW   = $clog2(N)
) (
   input  logic [N-1:0]  acc_i,
   input  logic [1:0]    op_i,
   input  logic [KW-1:0] k_i,
   output logic [N-1:0]  acc_o
);
   import riscv_pkg::*;

   // Mux over constant shift amounts; k_i is never larger than STEP, so k=0 passes through.
   always_comb begin
      acc_o = acc_i;
      for (int j = 1; j <= STEP; j++) begin
         if (k_i == KW'(j)) begin
            case (op_i)
               SHOP_SLL: acc_o = acc_i << j;
               SHOP_SRL: acc_o = acc_i >> j;
               SHOP_SRA: acc_o = $signed(acc_i) >>> j;
               default:  acc_o = (acc_i << j) | (acc_i >> (N - j));
            endcase
         end
      end
   end

endmodule

// File: rtl/nbit_iter_shifter.sv
// rtl/nbit_iter_shifter.sv - multi-cycle SLL/SRL/SRA/ROL shifter, STEP positions per cycle
module nbit_iter_shifter #(
   parameter int N       = 32,
   parameter int STEP    = 1,
   parameter int SHAMT_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [N-1:0]       operand,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               flush,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [N-1:0]       result
);
   import riscv_pkg::*;

   localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

   logic [1:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [N-1:0]       acc_q, acc_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [N-1:0]       result_q, result_d;
   logic [SHAMT_W-1:0] k;
   logic [N-1:0]       acc_step;
   logic               accept;

   assign ready  = (state_q != ST_SHIFT);
   assign busy   = (state_q == ST_SHIFT);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign accept = start & ready;
   assign k      = (rem_q < STEP_K) ? rem_q : STEP_K;

   nbit_shift_step #(
      .N    (N),
      .STEP (STEP),
      .KW   (SHAMT_W)
   ) u_step (
      .acc_i (acc_q),
      .op_i  (op_q),
      .k_i   (k),
      .acc_o (acc_step)
   );

   // result_q loads on the edge entering DONE, so it is valid with done and held afterwards.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      result_d = result_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  op_d  = op;
                  acc_d = operand;
                  rem_d = shamt;
                  if (shamt == '0) begin
                     state_d  = ST_DONE;
                     result_d = operand;
                  end else begin
                     state_d = ST_SHIFT;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               acc_d = acc_step;
               rem_d = rem_q - k;
               if (rem_q <= STEP_K) begin
                  state_d  = ST_DONE;
                  result_d = acc_step;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_nbit_iter_shifter.sv
// tb/tb_nbit_iter_shifter.sv - self-checking bench for nbit_iter_shifter (STEP=1 and STEP=4)
module tb_nbit_iter_shifter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_v [2];
   logic        flush_v [2];
   logic [1:0]  op_v    [2];
   logic [31:0] opnd_v  [2];
   logic [4:0]  shamt_v [2];
   logic [1:0]  ready_w, busy_w, done_w;
   logic [31:0] res0, res1;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   nbit_iter_shifter #(.N(32), .STEP(1)) dut_s1 (
      .clk(clk), .rst(rst), .start(start_v[0]), .op(op_v[0]), .operand(opnd_v[0]),
      .shamt(shamt_v[0]), .flush(flush_v[0]), .ready(ready_w[0]), .busy(busy_w[0]),
      .done(done_w[0]), .result(res0));

   nbit_iter_shifter #(.N(32), .STEP(4)) dut_s4 (
      .clk(clk), .rst(rst), .start(start_v[1]), .op(op_v[1]), .operand(opnd_v[1]),
      .shamt(shamt_v[1]), .flush(flush_v[1]), .ready(ready_w[1]), .busy(busy_w[1]),
      .done(done_w[1]), .result(res1));

   function automatic logic [31:0] res_of(input int u);
      return (u == 0) ? res0 : res1;
   endfunction

   function automatic int step_of(input int u);
      return (u == 0) ? 1 : 4;
   endfunction

   // Reference: shifts as multiplication/division by 2**s on 64-bit integers.
   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] x, input int s);
      longint unsigned p, v, w32;
      w32 = 64'h1_0000_0000;
      p   = 64'd1 << s;
      v   = {32'd0, x};
      case (o)
         2'b00:   return 32'((v * p) % w32);
         2'b01:   return 32'(v / p);
         2'b10:   return 32'(v / p + (x[31] ? (w32 - w32 / p) : 64'd0));
         default: return 32'((v * p) % w32 + (v * p) / w32);
      endcase
   endfunction

   task automatic do_op(input int u, input logic [1:0] o, input logic [31:0] x, input logic [4:0] s,
                        input logic [31:0] exp_res, input int exp_lat, input string nm);
      int lat, busy_cnt, w;
      w = 0;
      @(negedge clk);
      while (!ready_w[u] && w < 100) begin
         @(negedge clk);
         w++;
      end
      start_v[u] = 1'b1; op_v[u] = o; opnd_v[u] = x; shamt_v[u] = s;
      @(posedge clk); #1;
      start_v[u] = 1'b0; op_v[u] = 2'($urandom); opnd_v[u] = $urandom; shamt_v[u] = 5'($urandom);
      lat = 1;
      busy_cnt = 0;
      while (!done_w[u] && lat < 200) begin
         if (busy_w[u]) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      n_cmp++;
      if (lat !== exp_lat) begin
         n_err++;
         $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
      end
      n_cmp++;
      if (res_of(u) !== exp_res) begin
         n_err++;
         $display("FAIL %s result: got %h want %h", nm, res_of(u), exp_res);
      end
      n_cmp++;
      if (busy_cnt !== exp_lat - 1) begin
         n_err++;
         $display("FAIL %s busy cycles: got %0d want %0d", nm, busy_cnt, exp_lat - 1);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done_w[u] !== 1'b0 || res_of(u) !== exp_res) begin
         n_err++;
         $display("FAIL %s after done: done %b result %h want done 0 result %h", nm, done_w[u], res_of(u), exp_res);
      end
   endtask

   task automatic test_reset();
      #1;
      for (int u = 0; u < 2; u++) begin
         n_cmp++;
         if ({ready_w[u], busy_w[u], done_w[u]} !== 3'b100 || res_of(u) !== 32'd0) begin
            n_err++;
            $display("FAIL reset unit%0d: rdy/busy/done %b%b%b result %h want 100 00000000",
                     u, ready_w[u], busy_w[u], done_w[u], res_of(u));
         end
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
         n_cmp++;
         if ({ready_w[u], busy_w[u], done_w[u]} !== 3'b100) begin
            n_err++;
            $display("FAIL idle unit%0d: rdy/busy/done %b%b%b want 100", u, ready_w[u], busy_w[u], done_w[u]);
         end
      end
   endtask

   task automatic test_directed();
      do_op(0, 2'b00, 32'h0000_0001, 5'd5,  32'h0000_0020, 6, "sll1_by5");
      do_op(1, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, "sra4_by31");
      do_op(1, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9, "srl4_by31");
      do_op(1, 2'b11, 32'h8000_0001, 5'd4,  32'h0000_0018, 2, "rol4_by4");
      do_op(1, 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1, "shamt0");
      do_op(0, 2'b11, 32'hC000_0003, 5'd31, 32'hE000_0001, 32, "rol1_by31");
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] x;
      int          s;
      for (int i = 0; i < 24; i++) begin
         for (int u = 0; u < 2; u++) begin
            o = 2'($urandom);
            x = $urandom;
            s = (i < 2) ? i * 31 : $urandom_range(0, 31);
            do_op(u, o, x, 5'(s), ref_shift(o, x, s), 1 + (s + step_of(u) - 1) / step_of(u), "random");
         end
      end
   endtask

   task automatic test_back_to_back();
      int got;
      got = 0;
      @(negedge clk);
      start_v[0] = 1'b1; op_v[0] = 2'b00; opnd_v[0] = 32'h1; shamt_v[0] = 5'd3;
      @(posedge clk);
      for (int c = 0; c < 20 && got == 0; c++) begin
         @(negedge clk);
         if (done_w[0]) begin
            got = 1;
            n_cmp++;
            if (res0 !== 32'h8) begin
               n_err++;
               $display("FAIL b2b first result: got %h want 00000008", res0);
            end
            start_v[0] = 1'b1; op_v[0] = 2'b00; opnd_v[0] = 32'h3; shamt_v[0] = 5'd1;
         end else begin
            start_v[0] = 1'($urandom); op_v[0] = 2'($urandom);
            opnd_v[0] = $urandom; shamt_v[0] = 5'($urandom);
         end
      end
      n_cmp++;
      if (got !== 1) begin
         n_err++;
         $display("FAIL b2b first done: got %0d want 1", got);
      end
      @(negedge clk);
      start_v[0] = 1'b0;
      n_cmp++;
      if (busy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
         n_err++;
         $display("FAIL b2b no bubble: busy %b done %b want busy 1 done 0", busy_w[0], done_w[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (done_w[0] !== 1'b1 || res0 !== 32'h6) begin
         n_err++;
         $display("FAIL b2b second: done %b result %h want done 1 result 00000006", done_w[0], res0);
      end
   endtask

   task automatic test_flush();
      int pulses;
      do_op(0, 2'b00, 32'h1, 5'd2, 32'h4, 3, "flush_prior");
      @(negedge clk);
      start_v[0] = 1'b1; op_v[0] = 2'b00; opnd_v[0] = 32'h1; shamt_v[0] = 5'd10;
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush_v[0] = 1'b1; start_v[0] = 1'b1;
      @(negedge clk);
      flush_v[0] = 1'b0; start_v[0] = 1'b0;
      n_cmp++;
      if ({ready_w[0], busy_w[0], done_w[0]} !== 3'b100 || res0 !== 32'h4) begin
         n_err++;
         $display("FAIL flush abort: rdy/busy/done %b%b%b result %h want 100 00000004",
                  ready_w[0], busy_w[0], done_w[0], res0);
      end
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_w[0]) pulses++;
      end
      n_cmp++;
      if (pulses !== 0 || res0 !== 32'h4) begin
         n_err++;
         $display("FAIL flush no done: pulses %0d result %h want 0 00000004", pulses, res0);
      end
      start_v[0] = 1'b1; flush_v[0] = 1'b1; op_v[0] = 2'b00; opnd_v[0] = 32'h77; shamt_v[0] = 5'd0;
      @(negedge clk);
      start_v[0] = 1'b0; flush_v[0] = 1'b0;
      n_cmp++;
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || res0 !== 32'h4) begin
         n_err++;
         $display("FAIL flush over start: done %b busy %b result %h want 0 0 00000004", done_w[0], busy_w[0], res0);
      end
   endtask

   task automatic test_reset_mid();
      int pulses;
      @(negedge clk);
      start_v[1] = 1'b1; op_v[1] = 2'b01; opnd_v[1] = 32'hDEAD_BEEF; shamt_v[1] = 5'd31;
      @(posedge clk);
      @(negedge clk);
      start_v[1] = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({ready_w[1], busy_w[1], done_w[1]} !== 3'b100 || res1 !== 32'd0) begin
         n_err++;
         $display("FAIL async reset unit1: rdy/busy/done %b%b%b result %h want 100 00000000",
                  ready_w[1], busy_w[1], done_w[1], res1);
      end
      n_cmp++;
      if (res0 !== 32'd0) begin
         n_err++;
         $display("FAIL async reset unit0 result: got %h want 00000000", res0);
      end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (done_w[1]) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_err++;
         $display("FAIL reset no done: pulses %0d want 0", pulses);
      end
      do_op(1, 2'b11, 32'h8765_4321, 5'd13, ref_shift(2'b11, 32'h8765_4321, 13), 5, "after_reset");
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         start_v[u] = 1'b0; flush_v[u] = 1'b0; op_v[u] = 2'b00; opnd_v[u] = '0; shamt_v[u] = '0;
      end
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
